// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the packet-granular AXI-Stream round-robin arbiter.
// Holds the FSM encoding and a reference round-robin pick function.
package axis_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

  localparam int ARB_MAX_PORTS = 32;

  // First requester at or after ptr, searching upward with wrap; -1 when no request.
  function automatic int rr_next(input logic [ARB_MAX_PORTS-1:0] req, input int ptr, input int n);
    int j;
    rr_next = -1;
    for (int k = n - 1; k >= 0; k--) begin
      j = (ptr + k) % n;
      if (req[j]) rr_next = j;
    end
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: lowest request at or above ptr, else lowest overall.
// Zero latency; no flow control of its own.
module rr_pick #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] idx_o,
  output logic         found_o
);

  logic [2*N-1:0] dbl;
  int             pos;

  // Upper half is the unmasked request vector, so the lowest set bit of the
  // double-width word implements the wrap-around search.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      dbl[i]     = req_i[i] && (i >= int'(ptr_i));
      dbl[N + i] = req_i[i];
    end
    pos = 0;
    for (int i = 2 * N - 1; i >= 0; i--) begin
      if (dbl[i]) pos = i;
    end
    found_o = |req_i;
    idx_o   = (pos >= N) ? W'(pos - N) : W'(pos);
  end

endmodule

// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-granular round-robin AXIS arbiter: 1-cycle arbitration, then zero-latency forwarding until tlast.
// Backpressure: downstream tready is steered only to the granted source; all others see tready=0.
module axis_pkt_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter  int NUM_PORTS   = 4,
  parameter  int WIDTH_TDATA = 32,
  parameter  int WIDTH_TUSER = 1,
  parameter  int WIDTH_TID   = 1,
  parameter  int WIDTH_TKEEP = 4,
  localparam int WIDTH_SEL   = $clog2(NUM_PORTS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORTS-1:0]             axis_m_tvalid,
  input  logic [NUM_PORTS*WIDTH_TDATA-1:0] axis_m_tdata,
  input  logic [NUM_PORTS*WIDTH_TUSER-1:0] axis_m_tuser,
  input  logic [NUM_PORTS*WIDTH_TID-1:0]   axis_m_tid,
  input  logic [NUM_PORTS*WIDTH_TKEEP-1:0] axis_m_tkeep,
  input  logic [NUM_PORTS-1:0]             axis_m_tlast,
  output logic [NUM_PORTS-1:0]             axis_m_tready,
  output logic                             axis_s_tvalid,
  output logic [WIDTH_TDATA-1:0]           axis_s_tdata,
  output logic [WIDTH_TUSER-1:0]           axis_s_tuser,
  output logic [WIDTH_TID-1:0]             axis_s_tid,
  output logic [WIDTH_TKEEP-1:0]           axis_s_tkeep,
  output logic                             axis_s_tlast,
  output logic [WIDTH_SEL-1:0]             axis_s_tsel,
  input  logic                             axis_s_tready,
  output logic                             busy
);

  arb_state_t           state_q, state_d;
  logic [WIDTH_SEL-1:0] grant_q, grant_d;
  logic [WIDTH_SEL-1:0] rr_ptr_q, rr_ptr_d;
  logic [WIDTH_SEL-1:0] pick_idx;
  logic                 pick_found;
  logic                 locked;
  logic                 last_hs;

  rr_pick #(.N(NUM_PORTS)) u_pick (
    .req_i   (axis_m_tvalid),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  assign locked = (state_q == ARB_LOCKED);
  assign busy   = locked;

  // Data fields follow the grant register in both states; only valid is gated by state.
  assign axis_s_tvalid = locked && axis_m_tvalid[grant_q];
  assign axis_s_tdata  = axis_m_tdata[grant_q*WIDTH_TDATA +: WIDTH_TDATA];
  assign axis_s_tuser  = axis_m_tuser[grant_q*WIDTH_TUSER +: WIDTH_TUSER];
  assign axis_s_tid    = axis_m_tid[grant_q*WIDTH_TID +: WIDTH_TID];
  assign axis_s_tkeep  = axis_m_tkeep[grant_q*WIDTH_TKEEP +: WIDTH_TKEEP];
  assign axis_s_tlast  = axis_m_tlast[grant_q];
  assign axis_s_tsel   = grant_q;

  assign last_hs = axis_s_tvalid && axis_s_tready && axis_s_tlast;

  always_comb begin
    axis_m_tready = '0;
    if (locked) axis_m_tready[grant_q] = axis_s_tready;
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        if (last_hs) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = (grant_q == WIDTH_SEL'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// Directed bench for axis_pkt_rr_arbiter: per-port packet sources, a handshake log, and
// hand-computed expectations for each scenario.
module tb_axis_pkt_rr_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   m_tvalid;
  logic [127:0] m_tdata;
  logic [3:0]   m_tuser;
  logic [3:0]   m_tid;
  logic [15:0]  m_tkeep;
  logic [3:0]   m_tlast;
  logic [3:0]   m_tready;
  logic         s_tvalid;
  logic [31:0]  s_tdata;
  logic [0:0]   s_tuser;
  logic [0:0]   s_tid;
  logic [3:0]   s_tkeep;
  logic         s_tlast;
  logic [1:0]   s_tsel;
  logic         s_tready;
  logic         busy;

  int total = 0;
  int bad   = 0;

  // Per-port source model: nb beats per packet, pkts packets, data = base + beat index.
  bit          en   [4];
  bit          hold [4];
  int          nb   [4];
  int          bidx [4];
  int          pkts [4];
  logic [31:0] base [4];

  int          cyc_cnt;
  int          log_sel [$];
  logic [31:0] log_dat [$];
  logic        log_last[$];
  int          log_cyc [$];

  axis_pkt_rr_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .axis_m_tvalid (m_tvalid),
    .axis_m_tdata  (m_tdata),
    .axis_m_tuser  (m_tuser),
    .axis_m_tid    (m_tid),
    .axis_m_tkeep  (m_tkeep),
    .axis_m_tlast  (m_tlast),
    .axis_m_tready (m_tready),
    .axis_s_tvalid (s_tvalid),
    .axis_s_tdata  (s_tdata),
    .axis_s_tuser  (s_tuser),
    .axis_s_tid    (s_tid),
    .axis_s_tkeep  (s_tkeep),
    .axis_s_tlast  (s_tlast),
    .axis_s_tsel   (s_tsel),
    .axis_s_tready (s_tready),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_drive();
    for (int i = 0; i < 4; i++) begin
      m_tvalid[i]        = en[i] && !hold[i] && (bidx[i] < nb[i]);
      m_tdata[i*32 +: 32] = base[i] + 32'(bidx[i]);
      m_tlast[i]         = (bidx[i] == nb[i] - 1);
      m_tuser[i]         = (bidx[i] == 0);
      m_tid[i]           = i[0];
      m_tkeep[i*4 +: 4]  = 4'(15 - i);
    end
  endtask

  task automatic src_clear();
    for (int i = 0; i < 4; i++) begin
      en[i] = 0; hold[i] = 0; nb[i] = 1; bidx[i] = 0; pkts[i] = 0; base[i] = '0;
    end
    apply_drive();
  endtask

  task automatic src_load(input int p, input int beats, input int npk, input logic [31:0] b);
    en[p] = 1; hold[p] = 0; nb[p] = beats; bidx[p] = 0; pkts[p] = npk; base[p] = b;
    apply_drive();
  endtask

  // Called at a negedge: log the handshake, cross the posedge, advance sources, return at next negedge.
  task automatic cyc();
    logic [3:0] hs;
    hs = m_tvalid & m_tready;
    if (s_tvalid && s_tready) begin
      log_sel.push_back(int'(s_tsel));
      log_dat.push_back(s_tdata);
      log_last.push_back(s_tlast);
      log_cyc.push_back(cyc_cnt);
    end
    @(posedge clk);
    #1;
    cyc_cnt++;
    for (int i = 0; i < 4; i++) begin
      if (hs[i]) begin
        bidx[i]++;
        if (bidx[i] == nb[i]) begin
          pkts[i]--;
          if (pkts[i] > 0) begin
            bidx[i] = 0;
            base[i] = base[i] + 32'h10;
          end else begin
            en[i] = 0;
          end
        end
      end
    end
    apply_drive();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    src_clear();
    s_tready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc_cnt = 0;
    log_sel.delete(); log_dat.delete(); log_last.delete(); log_cyc.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    s_tready = 1'b1;
    src_clear();
    m_tvalid = 4'hF;
    #3;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    total++; if (s_tvalid !== 1'b0) begin bad++; $display("FAIL rst_s_tvalid got=%0b exp=0", s_tvalid); end
    total++; if (m_tready !== 4'h0) begin bad++; $display("FAIL rst_m_tready got=%0h exp=0", m_tready); end
    total++; if (s_tsel !== 2'd0) begin bad++; $display("FAIL rst_tsel got=%0d exp=0", s_tsel); end
    do_reset();
  endtask

  task automatic test_single_port();
    do_reset();
    src_load(2, 3, 1, 32'hA);
    total++; if (s_tvalid !== 1'b0 || m_tready !== 4'h0) begin bad++; $display("FAIL t1_bubble got=%0b/%0h exp=0/0", s_tvalid, m_tready); end
    cyc();
    total++; if (s_tvalid !== 1'b1 || s_tdata !== 32'hA) begin bad++; $display("FAIL t1_beat0 got=%0b/%0h exp=1/a", s_tvalid, s_tdata); end
    total++; if (s_tsel !== 2'd2 || m_tready !== 4'b0100) begin bad++; $display("FAIL t1_sel got=%0d/%0h exp=2/4", s_tsel, m_tready); end
    total++; if (s_tkeep !== 4'hD || s_tuser !== 1'b1 || s_tid !== 1'b0) begin bad++; $display("FAIL t1_side got=%0h/%0b/%0b exp=d/1/0", s_tkeep, s_tuser, s_tid); end
    cyc();
    total++; if (s_tdata !== 32'hB || s_tlast !== 1'b0) begin bad++; $display("FAIL t1_beat1 got=%0h/%0b exp=b/0", s_tdata, s_tlast); end
    cyc();
    total++; if (s_tdata !== 32'hC || s_tlast !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL t1_beat2 got=%0h/%0b/%0b exp=c/1/1", s_tdata, s_tlast, busy); end
    cyc();
    total++; if (busy !== 1'b0 || s_tvalid !== 1'b0) begin bad++; $display("FAIL t1_done got=%0b/%0b exp=0/0", busy, s_tvalid); end
    total++; if (log_dat.size() !== 3) begin bad++; $display("FAIL t1_count got=%0d exp=3", log_dat.size()); end
  endtask

  task automatic test_round_robin();
    int          exp_sel [10];
    logic [31:0] exp_dat [10];
    exp_sel = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    exp_dat = '{32'h100, 32'h101, 32'h200, 32'h201, 32'h300, 32'h301, 32'h400, 32'h401, 32'h110, 32'h111};
    do_reset();
    src_load(0, 2, 2, 32'h100);
    src_load(1, 2, 1, 32'h200);
    src_load(2, 2, 1, 32'h300);
    src_load(3, 2, 1, 32'h400);
    for (int k = 0; k < 16; k++) cyc();
    total++; if (log_sel.size() !== 10) begin bad++; $display("FAIL t2_count got=%0d exp=10", log_sel.size()); end
    for (int j = 0; j < 10 && j < log_sel.size(); j++) begin
      total++; if (log_sel[j] !== exp_sel[j] || log_dat[j] !== exp_dat[j]) begin bad++; $display("FAIL t2_beat%0d got=%0d/%0h exp=%0d/%0h", j, log_sel[j], log_dat[j], exp_sel[j], exp_dat[j]); end
      total++; if (log_last[j] !== 1'(j % 2) || log_cyc[j] !== 1 + 3 * (j / 2) + (j % 2)) begin bad++; $display("FAIL t2_time%0d got=%0b/%0d exp=%0b/%0d", j, log_last[j], log_cyc[j], j % 2, 1 + 3 * (j / 2) + (j % 2)); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    src_load(1, 3, 1, 32'h200);
    src_load(3, 1, 1, 32'h330);
    cyc();
    total++; if (s_tsel !== 2'd1 || s_tdata !== 32'h200) begin bad++; $display("FAIL t3_grant got=%0d/%0h exp=1/200", s_tsel, s_tdata); end
    cyc();
    s_tready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++; if (s_tdata !== 32'h201 || m_tready !== 4'h0 || s_tvalid !== 1'b1) begin bad++; $display("FAIL t3_stall%0d got=%0h/%0h/%0b exp=201/0/1", k, s_tdata, m_tready, s_tvalid); end
      cyc();
    end
    s_tready = 1'b1;
    #1;
    total++; if (m_tready !== 4'b0010 || s_tdata !== 32'h201) begin bad++; $display("FAIL t3_resume got=%0h/%0h exp=2/201", m_tready, s_tdata); end
    cyc();
    total++; if (s_tdata !== 32'h202 || s_tlast !== 1'b1) begin bad++; $display("FAIL t3_last got=%0h/%0b exp=202/1", s_tdata, s_tlast); end
    cyc();
    cyc();
    total++; if (s_tsel !== 2'd3 || s_tdata !== 32'h330) begin bad++; $display("FAIL t3_next got=%0d/%0h exp=3/330", s_tsel, s_tdata); end
    cyc();
    total++; if (log_dat.size() !== 4) begin bad++; $display("FAIL t3_count got=%0d exp=4", log_dat.size()); end
  endtask

  task automatic test_valid_gap();
    do_reset();
    src_load(0, 3, 1, 32'h300);
    src_load(3, 1, 1, 32'h330);
    cyc();
    total++; if (s_tsel !== 2'd0 || s_tdata !== 32'h300) begin bad++; $display("FAIL t4_grant got=%0d/%0h exp=0/300", s_tsel, s_tdata); end
    cyc();
    hold[0] = 1;
    apply_drive();
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (s_tvalid !== 1'b0 || busy !== 1'b1 || s_tsel !== 2'd0 || m_tready[3] !== 1'b0) begin bad++; $display("FAIL t4_gap%0d got=%0b/%0b/%0d/%0b exp=0/1/0/0", k, s_tvalid, busy, s_tsel, m_tready[3]); end
      cyc();
    end
    hold[0] = 0;
    apply_drive();
    #1;
    total++; if (s_tdata !== 32'h301 || s_tvalid !== 1'b1) begin bad++; $display("FAIL t4_resume got=%0h/%0b exp=301/1", s_tdata, s_tvalid); end
    cyc();
    total++; if (s_tdata !== 32'h302 || s_tlast !== 1'b1 || s_tsel !== 2'd0) begin bad++; $display("FAIL t4_last got=%0h/%0b/%0d exp=302/1/0", s_tdata, s_tlast, s_tsel); end
    cyc();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL t4_bubble got=%0b exp=0", busy); end
    cyc();
    total++; if (s_tsel !== 2'd3 || s_tdata !== 32'h330 || s_tvalid !== 1'b1) begin bad++; $display("FAIL t4_port3 got=%0d/%0h/%0b exp=3/330/1", s_tsel, s_tdata, s_tvalid); end
    cyc();
  endtask

  task automatic test_async_reset();
    do_reset();
    src_load(2, 1, 1, 32'h4F0);
    cyc();
    cyc();
    src_load(2, 4, 1, 32'h500);
    cyc();
    cyc();
    total++; if (s_tdata !== 32'h501 || busy !== 1'b1) begin bad++; $display("FAIL t5_mid got=%0h/%0b exp=501/1", s_tdata, busy); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (s_tvalid !== 1'b0 || m_tready !== 4'h0 || busy !== 1'b0) begin bad++; $display("FAIL t5_async got=%0b/%0h/%0b exp=0/0/0", s_tvalid, m_tready, busy); end
    @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL t5_held got=%0b exp=0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    src_load(2, 4, 1, 32'h500);
    src_load(3, 1, 1, 32'h530);
    cyc();
    total++; if (s_tsel !== 2'd2 || s_tdata !== 32'h500 || s_tvalid !== 1'b1) begin bad++; $display("FAIL t5_rearb got=%0d/%0h/%0b exp=2/500/1", s_tsel, s_tdata, s_tvalid); end
  endtask

  task automatic test_single_beat();
    do_reset();
    src_load(0, 1, 1, 32'h600);
    src_load(1, 1, 1, 32'h610);
    cyc();
    total++; if (s_tsel !== 2'd0 || s_tdata !== 32'h600 || s_tlast !== 1'b1 || s_tvalid !== 1'b1) begin bad++; $display("FAIL t6_p0 got=%0d/%0h/%0b/%0b exp=0/600/1/1", s_tsel, s_tdata, s_tlast, s_tvalid); end
    cyc();
    total++; if (busy !== 1'b0 || s_tvalid !== 1'b0) begin bad++; $display("FAIL t6_idle got=%0b/%0b exp=0/0", busy, s_tvalid); end
    cyc();
    total++; if (s_tsel !== 2'd1 || s_tdata !== 32'h610 || s_tlast !== 1'b1 || s_tvalid !== 1'b1) begin bad++; $display("FAIL t6_p1 got=%0d/%0h/%0b/%0b exp=1/610/1/1", s_tsel, s_tdata, s_tlast, s_tvalid); end
    cyc();
    total++; if (busy !== 1'b0 || log_dat.size() !== 2) begin bad++; $display("FAIL t6_end got=%0b/%0d exp=0/2", busy, log_dat.size()); end
  endtask

  initial begin
    cyc_cnt = 0;
    test_reset();
    test_single_port();
    test_round_robin();
    test_backpressure();
    test_valid_gap();
    test_async_reset();
    test_single_beat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
